// File: rtl/aes_pkg.sv
// Shared AES constants, S-box and round-constant lookup for the key schedule.
package aes_pkg;

   localparam int ROUNDS    = 10;
   localparam int WORD_SIZE = 32;
   localparam int KEY_SIZE  = 128;
   localparam int RND_W     = $clog2(ROUNDS) + 1;

   typedef enum logic [1:0] {IDLE, FWD, READY} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constant byte for rounds 1..10; any other index yields zero.
   function automatic logic [7:0] rcon_f(input logic [RND_W-1:0] round);
      logic [7:0] rc;
      rc = 8'h00;
      case (round)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_key_sched_rev_if.sv
// Key-load and round-key delivery bundle between key source, schedule and round engine.
interface aes_key_sched_rev_if;
   import aes_pkg::*;

   logic                key_valid;
   logic [KEY_SIZE-1:0] key_in;
   logic                key_ready;
   logic                rk_req;
   logic                rk_valid;
   logic [KEY_SIZE-1:0] rk_out;
   logic [RND_W-1:0]    rk_round;
   logic                rk_last;
   logic                busy;

   modport master (
      output key_valid, key_in, rk_req,
      input  key_ready, rk_valid, rk_out, rk_round, rk_last, busy
   );

   modport slave (
      input  key_valid, key_in, rk_req,
      output key_ready, rk_valid, rk_out, rk_round, rk_last, busy
   );

endinterface

// File: rtl/aes_key_sched_rev_sub_word.sv
// Combinational AES SubWord: four parallel S-box byte lookups.
module sub_word
   import aes_pkg::*;
(
   input  logic [WORD_SIZE-1:0] word_i,
   output logic [WORD_SIZE-1:0] word_o
);

   genvar gi;
   generate
      for (gi = 0; gi < WORD_SIZE / 8; gi++) begin : g_byte
         assign word_o[8*gi +: 8] = SBOX[word_i[8*gi +: 8]];
      end
   endgenerate

endmodule

// File: rtl/aes_key_sched_rev.sv
// Reverse-order AES-128 key schedule: expands forward to round 10, then walks
// back to round 0 one key per handshake by inverting the expansion step.
module aes_key_sched_rev
   import aes_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   aes_key_sched_rev_if.slave bus
);

   state_t              state_q, state_d;
   logic [KEY_SIZE-1:0] work_q, work_d;
   logic [KEY_SIZE-1:0] shadow_q, shadow_d;
   logic [RND_W-1:0]    cnt_q, cnt_d;
   logic [RND_W-1:0]    round_q, round_d;

   logic [WORD_SIZE-1:0] w0, w1, w2, w3;
   logic [WORD_SIZE-1:0] p3, sw_src, sw_in, sw_out, rcon_word, t0;
   logic [WORD_SIZE-1:0] n0, n1, n2, n3;
   logic [RND_W-1:0]     rcon_round;
   logic [KEY_SIZE-1:0]  fwd_key, inv_key;
   logic                 key_accept;

   assign {w0, w1, w2, w3} = work_q;

   // The single SubWord is fed w3 going forward and the recovered p3 going back.
   assign p3     = w3 ^ w2;
   assign sw_src = (state_q == FWD) ? w3 : p3;
   assign sw_in  = {sw_src[WORD_SIZE-9:0], sw_src[WORD_SIZE-1 -: 8]};

   sub_word u_sub_word (
      .word_i (sw_in),
      .word_o (sw_out)
   );

   assign rcon_round = (state_q == FWD) ? cnt_q : round_q;
   assign rcon_word  = {rcon_f(rcon_round), {(WORD_SIZE-8){1'b0}}};
   assign t0         = w0 ^ sw_out ^ rcon_word;

   assign n0      = t0;
   assign n1      = w1 ^ n0;
   assign n2      = w2 ^ n1;
   assign n3      = w3 ^ n2;
   assign fwd_key = {n0, n1, n2, n3};
   assign inv_key = {t0, w1 ^ w0, w2 ^ w1, p3};

   assign key_accept = bus.key_valid && (state_q != FWD);

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      round_d  = round_q;
      case (state_q)
         IDLE: begin
            if (key_accept) begin
               work_d  = bus.key_in;
               cnt_d   = RND_W'(1);
               state_d = FWD;
            end
         end
         FWD: begin
            work_d = fwd_key;
            if (cnt_q == RND_W'(ROUNDS)) begin
               shadow_d = fwd_key;
               round_d  = RND_W'(ROUNDS);
               state_d  = READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         READY: begin
            // A new key takes priority over any pending round-key request.
            if (key_accept) begin
               work_d  = bus.key_in;
               cnt_d   = RND_W'(1);
               state_d = FWD;
            end else if (bus.rk_req) begin
               if (round_q == '0) begin
                  work_d  = shadow_q;
                  round_d = RND_W'(ROUNDS);
               end else begin
                  work_d  = inv_key;
                  round_d = round_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         work_q   <= '0;
         shadow_q <= '0;
         cnt_q    <= '0;
         round_q  <= '0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         round_q  <= round_d;
      end
   end

   assign bus.key_ready = (state_q != FWD);
   assign bus.busy      = (state_q == FWD);
   assign bus.rk_valid  = (state_q == READY);
   assign bus.rk_out    = work_q;
   assign bus.rk_round  = round_q;
   assign bus.rk_last   = (state_q == READY) && (round_q == '0);

endmodule

// File: tb/tb_aes_key_sched_rev.sv
// Randomised bench for the reverse key schedule, checked every cycle against a
// model that precomputes all eleven round keys with a textbook key expansion.
module tb_aes_key_sched_rev;

   typedef logic [10:0][127:0] key_arr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   aes_key_sched_rev_if bus ();

   aes_key_sched_rev dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   logic [7:0] sbox_m [256];
   logic [7:0] rcon_m [11];
   int         n_checks = 0;
   int         n_pass   = 0;
   bit         lit_en   = 1'b0;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   // Textbook forward expansion into 44 words, grouped into 11 round keys.
   function automatic key_arr_t expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      key_arr_t    r;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_m[i/4], 24'h0};
         w[i] = w[i-4] ^ t;
      end
      for (int rr = 0; rr < 11; rr++) r[rr] = {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
      return r;
   endfunction

   // Behavioural model: expected handshake-visible state.
   logic     m_busy  = 1'b0;
   logic     m_valid = 1'b0;
   logic     m_zero  = 1'b1;
   logic [3:0] m_round = 4'd0;
   int       m_left  = 0;
   key_arr_t m_keys  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_zero  <= 1'b1;
         m_round <= 4'd0;
         m_left  <= 0;
      end else if (bus.key_valid && !m_busy) begin
         m_keys  <= expand(bus.key_in);
         m_busy  <= 1'b1;
         m_valid <= 1'b0;
         m_zero  <= 1'b0;
         m_left  <= 10;
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b1;
            m_round <= 4'd10;
         end
      end else if (m_valid && bus.rk_req) begin
         m_round <= (m_round == 4'd0) ? 4'd10 : m_round - 4'd1;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Compare process: outputs sampled on the falling edge.
   always @(negedge clk) begin
      logic [127:0] lit;
      bit           has_lit;
      chk("key_ready", 128'(bus.key_ready), 128'(!m_busy));
      chk("busy",      128'(bus.busy),      128'(m_busy));
      chk("rk_valid",  128'(bus.rk_valid),  128'(m_valid));
      chk("rk_last",   128'(bus.rk_last),   128'(m_valid && m_round == 4'd0));
      if (m_valid) begin
         chk("rk_round", 128'(bus.rk_round), 128'(m_round));
         chk("rk_out",   bus.rk_out,         m_keys[m_round]);
      end
      if (m_zero) begin
         chk("reset_rk_out",   bus.rk_out,          128'd0);
         chk("reset_rk_round", 128'(bus.rk_round),  128'd0);
      end
      has_lit = 1'b1;
      lit     = '0;
      case (m_round)
         4'd10:   lit = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
         4'd9:    lit = 128'hac7766f319fadc2128d12941575c006e;
         4'd1:    lit = 128'ha0fafe1788542cb123a339392a6c7605;
         4'd0:    lit = 128'h2b7e151628aed2a6abf7158809cf4f3c;
         default: has_lit = 1'b0;
      endcase
      if (lit_en && m_valid && has_lit) begin
         chk("fips_model", m_keys[m_round], lit);
         chk("fips_dut",   bus.rk_out,      lit);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [127:0] k);
      bus.key_valid = 1'b1;
      bus.key_in    = k;
      $display("load key %h at %0t", k, $time);
      tick();
      bus.key_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (bus.rk_valid) return;
         tick();
      end
      $display("FAIL wait_valid_%s: rk_valid still 0, required 1 within 20 cycles", tag);
      $fatal(1, "timeout");
   endtask

   task automatic wait_round(input logic [3:0] r);
      for (int i = 0; i < 30; i++) begin
         if (bus.rk_valid && bus.rk_round == r) return;
         tick();
      end
      $display("FAIL wait_round: rk_round never reached %0d, last %0d", r, bus.rk_round);
      $fatal(1, "timeout");
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [7:0] inv;
      logic [7:0] rc;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      rc = 8'h01;
      rcon_m[0] = 8'h00;
      for (int i = 1; i < 11; i++) begin
         rcon_m[i] = rc;
         rc = xtime(rc);
      end

      bus.key_valid = 1'b0;
      bus.key_in    = '0;
      bus.rk_req    = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // FIPS-197 key, rk_req held through round 0 and a replay.
      lit_en     = 1'b1;
      bus.rk_req = 1'b1;
      send_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
      wait_valid("fips");
      repeat (16) tick();
      bus.rk_req = 1'b0;
      tick();
      lit_en = 1'b0;

      // Random backpressure on the same key.
      repeat (80) begin
         bus.rk_req = 1'($urandom_range(0, 1));
         tick();
      end

      // New key while in READY at round 5 with rk_req high, then key_valid held through FWD.
      bus.rk_req = 1'b1;
      wait_round(4'd5);
      send_key(rand_key());
      bus.key_valid = 1'b1;
      bus.key_in    = rand_key();
      repeat (6) tick();
      bus.key_valid = 1'b0;
      wait_valid("newkey");
      repeat (30) begin
         bus.rk_req = 1'($urandom_range(0, 1));
         tick();
      end

      // Reset pulse during forward expansion, then a fresh load.
      bus.rk_req = 1'b0;
      send_key(rand_key());
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      send_key(rand_key());
      wait_valid("postreset");
      bus.rk_req = 1'b1;
      repeat (14) tick();

      // Back-to-back random keys loaded from READY.
      repeat (4) begin
         send_key(rand_key());
         wait_valid("loop");
         repeat (30) begin
            bus.rk_req = 1'($urandom_range(0, 1));
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
